// File: rtl/regfile_wb_driver.sv
// regfile_wb_driver
//   Write-side driver for the 64-bit, 32-entry register file. It merges
//   full-width ALU results and buffered sub-word load returns onto the
//   single register-file write port, so the file sees at most one write
//   per cycle. Loads are queued in a small FIFO together with a byte-lane
//   mask computed at acceptance. A starvation counter forces the FIFO head
//   through after STARVE_LIMIT consecutive lost arbitrations.
//
//   Optional feature macro: WB_ZERO_FILTER_EN
//     defined   - writes to register 0 are consumed but issue with RegWrite=0
//     undefined - writes to register 0 are driven with RegWrite=1
//
// Ports (vectors are [0:N-1], bit 0 most significant; byte lane 0 = bits 0..7)
//   CLK, RST_N           clock, asynchronous active-low reset
//   ALU_VALID/READY      ALU result handshake (READY is combinational)
//   ALU_ADDR/DATA        ALU destination and 64-bit result
//   LD_VALID/READY       load-return handshake (READY is registered)
//   LD_ADDR/DATA         load destination and raw aligned doubleword
//   LD_SIZE/OFFSET       log2 byte count and starting byte lane
//   RegWrite             register-file write strobe
//   W_ADDR/DATA/MASK     write address, data and byte-lane enables
//   LD_ERR               one-cycle pulse: accepted load ran past lane 7
//   FIFO_LEVEL           current load FIFO occupancy
module regfile_wb_driver #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   ALU_VALID,
    output logic                   ALU_READY,
    input  logic [0:4]             ALU_ADDR,
    input  logic [0:63]            ALU_DATA,
    input  logic                   LD_VALID,
    output logic                   LD_READY,
    input  logic [0:4]             LD_ADDR,
    input  logic [0:63]            LD_DATA,
    input  logic [0:1]             LD_SIZE,
    input  logic [0:2]             LD_OFFSET,
    output logic                   RegWrite,
    output logic [0:4]             W_ADDR,
    output logic [0:63]            W_DATA,
    output logic [0:7]             W_MASK,
    output logic                   LD_ERR,
    output logic [0:$clog2(DEPTH)] FIFO_LEVEL
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_ALU,
        GNT_LD,
        GNT_LD_FORCE
    } gnt_e;

    logic [0:4]  addr_mem [DEPTH];
    logic [0:63] data_mem [DEPTH];
    logic [0:7]  mask_mem [DEPTH];

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0] count_q, count_d;
    logic [7:0]    starve_q, starve_d;
    logic          ld_ready_q, ld_ready_d;
    logic          ld_err_q, ld_err_d;
    logic          regwrite_q, regwrite_d;
    logic [0:4]    waddr_q, waddr_d;
    logic [0:63]   wdata_q, wdata_d;
    logic [0:7]    wmask_q, wmask_d;

    gnt_e       gnt;
    logic       fifo_ne, force_ld, push, pop, issue;
    logic [0:7] ld_mask;
    logic       ld_over;
    logic [3:0] lane_lo, lane_hi;

    // Lanes OFFSET .. OFFSET+2^SIZE-1, clipped at lane 7; lane_hi is exclusive.
    always_comb begin
        lane_lo = {1'b0, LD_OFFSET};
        lane_hi = lane_lo + (4'd1 << LD_SIZE);
        ld_over = (lane_hi > 4'd8);
        ld_mask = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            ld_mask[i[2:0]] = (4'(i) >= lane_lo) && (4'(i) < lane_hi);
        end
    end

    assign fifo_ne   = (count_q != '0);
    assign force_ld  = fifo_ne && (starve_q == 8'(STARVE_LIMIT));
    assign ALU_READY = !force_ld;
    assign push      = LD_VALID && ld_ready_q;

    // Arbitration uses the registered occupancy, so a load pushed this
    // cycle cannot also be popped this cycle.
    always_comb begin
        gnt = GNT_IDLE;
        if (force_ld) begin
            gnt = GNT_LD_FORCE;
        end else if (ALU_VALID) begin
            gnt = GNT_ALU;
        end else if (fifo_ne) begin
            gnt = GNT_LD;
        end
    end

    assign pop   = (gnt == GNT_LD) || (gnt == GNT_LD_FORCE);
    assign issue = (gnt != GNT_IDLE);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) wptr_d = wptr_q + PW'(1);
        if (pop)  rptr_d = rptr_q + PW'(1);
        if (push && !pop) begin
            count_d = count_q + LW'(1);
        end else if (pop && !push) begin
            count_d = count_q - LW'(1);
        end
        ld_ready_d = (count_d != LW'(DEPTH));
        ld_err_d   = push && ld_over;

        starve_d = starve_q;
        if (!fifo_ne || pop) begin
            starve_d = '0;
        end else if ((gnt == GNT_ALU) && (starve_q != 8'(STARVE_LIMIT))) begin
            starve_d = starve_q + 8'd1;
        end

        // Write bus holds its last value while idle; only RegWrite qualifies it.
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        if (pop) begin
            waddr_d = addr_mem[rptr_q];
            wdata_d = data_mem[rptr_q];
            wmask_d = mask_mem[rptr_q];
        end else if (gnt == GNT_ALU) begin
            waddr_d = ALU_ADDR;
            wdata_d = ALU_DATA;
            wmask_d = '1;
        end

`ifdef WB_ZERO_FILTER_EN
        regwrite_d = issue && (waddr_d != '0);
`else
        regwrite_d = issue;
`endif
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            addr_mem[wptr_q] <= LD_ADDR;
            data_mem[wptr_q] <= LD_DATA;
            mask_mem[wptr_q] <= ld_mask;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            ld_ready_q <= 1'b0;
            ld_err_q   <= 1'b0;
            regwrite_q <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            ld_ready_q <= ld_ready_d;
            ld_err_q   <= ld_err_d;
            regwrite_q <= regwrite_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
        end
    end

    assign LD_READY   = ld_ready_q;
    assign LD_ERR     = ld_err_q;
    assign RegWrite   = regwrite_q;
    assign W_ADDR     = waddr_q;
    assign W_DATA     = wdata_q;
    assign W_MASK     = wmask_q;
    assign FIFO_LEVEL = count_q;

endmodule

// File: tb/tb_regfile_wb_driver.sv
// tb_regfile_wb_driver
//   Scoreboard bench for regfile_wb_driver. A transaction model of the
//   arbitration, load FIFO and starve counter predicts each write when the
//   stimulus is driven; the prediction is queued and compared when the DUT
//   presents the registered write one cycle later.
`timescale 1ns/1ps
module tb_regfile_wb_driver;
    localparam int unsigned DEPTH        = 4;
    localparam int unsigned STARVE_LIMIT = 8;
    localparam int unsigned LW           = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          ALU_VALID, ALU_READY;
    logic [0:4]    ALU_ADDR;
    logic [0:63]   ALU_DATA;
    logic          LD_VALID, LD_READY;
    logic [0:4]    LD_ADDR;
    logic [0:63]   LD_DATA;
    logic [0:1]    LD_SIZE;
    logic [0:2]    LD_OFFSET;
    logic          RegWrite;
    logic [0:4]    W_ADDR;
    logic [0:63]   W_DATA;
    logic [0:7]    W_MASK;
    logic          LD_ERR;
    logic [0:LW-1] FIFO_LEVEL;

    always #5 CLK = ~CLK;

    regfile_wb_driver #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .ALU_VALID  (ALU_VALID),
        .ALU_READY  (ALU_READY),
        .ALU_ADDR   (ALU_ADDR),
        .ALU_DATA   (ALU_DATA),
        .LD_VALID   (LD_VALID),
        .LD_READY   (LD_READY),
        .LD_ADDR    (LD_ADDR),
        .LD_DATA    (LD_DATA),
        .LD_SIZE    (LD_SIZE),
        .LD_OFFSET  (LD_OFFSET),
        .RegWrite   (RegWrite),
        .W_ADDR     (W_ADDR),
        .W_DATA     (W_DATA),
        .W_MASK     (W_MASK),
        .LD_ERR     (LD_ERR),
        .FIFO_LEVEL (FIFO_LEVEL)
    );

    typedef struct packed {
        logic [0:4]  a;
        logic [0:63] d;
        logic [0:7]  m;
    } wr_t;

    wr_t         mq[$];   // model load FIFO
    wr_t         exq[$];  // expected writes
    int unsigned m_starve;
    logic        m_ready;
    logic        m_err;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic at, lt, rdy;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void ld_lanes(input logic [1:0] s, input logic [2:0] o,
                                     output logic [0:7] m, output logic e);
        int unsigned n;
        int unsigned first;
        n     = 1 << s;
        first = o;
        m     = '0;
        e     = 1'b0;
        for (int unsigned k = first; k < first + n; k++) begin
            if (k < 8) m[k] = 1'b1;
            else       e    = 1'b1;
        end
    endfunction

    // Called on a negedge; returns on the following negedge.
    task automatic cycle(input logic av, input logic [0:4] aa, input logic [0:63] ad,
                         input logic lv, input logic [0:4] la, input logic [0:63] ldd,
                         input logic [1:0] ls, input logic [2:0] lo,
                         output logic alu_taken, output logic ld_taken, output logic rdy_obs);
        logic       ne, force_ld, issued, we, er;
        logic [0:7] mk;
        wr_t        w, nl, got;

        ALU_VALID = av;  ALU_ADDR = aa;  ALU_DATA = ad;
        LD_VALID  = lv;  LD_ADDR  = la;  LD_DATA  = ldd;
        LD_SIZE   = ls;  LD_OFFSET = lo;

        ne        = (mq.size() != 0);
        force_ld  = ne && (m_starve == STARVE_LIMIT);
        alu_taken = 1'b0;
        issued    = 1'b0;
        w         = '0;
        if (force_ld || (!av && ne)) begin
            w      = mq.pop_front();
            issued = 1'b1;
        end else if (av) begin
            w.a       = aa;
            w.d       = ad;
            w.m       = 8'hFF;
            issued    = 1'b1;
            alu_taken = 1'b1;
        end
        if (!ne)            m_starve = 0;
        else if (alu_taken) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT;
        else                m_starve = 0;

        ld_taken = lv && m_ready;
        m_err    = 1'b0;
        if (ld_taken) begin
            ld_lanes(ls, lo, mk, er);
            nl.a = la;
            nl.d = ldd;
            nl.m = mk;
            mq.push_back(nl);
            m_err = er;
        end
        if (issued) exq.push_back(w);
        m_ready = (mq.size() != DEPTH);
`ifdef WB_ZERO_FILTER_EN
        we = issued && (w.a != 5'd0);
`else
        we = issued;
`endif

        #1;
        rdy_obs = ALU_READY;
        check("alu_ready", ALU_READY, !force_ld);
        @(posedge CLK);
        #1;
        check("regwrite", RegWrite, we);
        if (RegWrite || issued) begin
            if (exq.size() == 0) begin
                check("spurious_write", 1, 0);
            end else begin
                got = exq.pop_front();
                check("w_addr", W_ADDR, got.a);
                check("w_data", W_DATA, got.d);
                check("w_mask", W_MASK, got.m);
            end
        end
        check("ld_err", LD_ERR, m_err);
        check("ld_ready", LD_READY, m_ready);
        check("fifo_level", FIFO_LEVEL, mq.size());
        @(negedge CLK);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++)
            cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 2'd0, 3'd0, at, lt, rdy);
    endtask

    task automatic drain();
        for (int unsigned i = 0; i < 64 && mq.size() != 0; i++) idle(1);
        if (mq.size() != 0) check("drain_timeout", mq.size(), 0);
        idle(1);
    endtask

    task automatic do_reset();
        ALU_VALID = 1'b0;
        LD_VALID  = 1'b0;
        RST_N     = 1'b0;
        mq.delete();
        exq.delete();
        m_starve = 0;
        m_ready  = 1'b0;
        m_err    = 1'b0;
        #1;
        check("rst_regwrite", RegWrite, 0);
        check("rst_w_addr", W_ADDR, 0);
        check("rst_w_data", W_DATA, 0);
        check("rst_w_mask", W_MASK, 0);
        check("rst_ld_err", LD_ERR, 0);
        check("rst_fifo_level", FIFO_LEVEL, 0);
        check("rst_ld_ready", LD_READY, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        int unsigned alu_cnt, wins, n_ld;
        logic        done, full_seen, a_pend, l_pend;
        logic [0:4]  a_addr, l_addr;
        logic [0:63] a_data, l_data;
        logic [1:0]  l_size;
        logic [2:0]  l_off;

        RST_N     = 1'b1;
        ALU_VALID = 1'b0;  ALU_ADDR = '0;  ALU_DATA = '0;
        LD_VALID  = 1'b0;  LD_ADDR  = '0;  LD_DATA  = '0;
        LD_SIZE   = '0;    LD_OFFSET = '0;
        #2;
        do_reset();
        idle(1);

        // ALU path
        cycle(1'b1, 5'd5, 64'h0123456789ABCDEF, 1'b0, 5'd0, 64'd0, 2'd0, 3'd0, at, lt, rdy);
        idle(1);

        // Load masks, including lane-7 overrun and boundary cases
        cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'hDEADBEEFCAFEF00D, 2'd1, 3'd2, at, lt, rdy);
        idle(2);
        cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h1122334455667788, 2'd2, 3'd6, at, lt, rdy);
        idle(2);
        cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd10, 64'hA5A5A5A5A5A5A5A5, 2'd0, 3'd7, at, lt, rdy);
        cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd11, 64'h0F0F0F0F0F0F0F0F, 2'd3, 3'd1, at, lt, rdy);
        cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd12, 64'hFEDCBA9876543210, 2'd3, 3'd0, at, lt, rdy);
        drain();

        // Destination 0 from both producers
        cycle(1'b1, 5'd0, 64'hCAFEBABE00000000, 1'b0, 5'd0, 64'd0, 2'd0, 3'd0, at, lt, rdy);
        cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'h00000000CAFEBABE, 2'd3, 3'd0, at, lt, rdy);
        drain();

        // Starvation: ALU held continuously, one load queued alongside
        alu_cnt = 0;
        cycle(1'b1, 5'd3, 64'hA000 + 64'(alu_cnt), 1'b1, 5'd13, 64'h5555AAAA5555AAAA,
              2'd3, 3'd0, at, lt, rdy);
        if (at) alu_cnt++;
        wins = 0;
        done = 1'b0;
        for (int unsigned i = 0; i < 20 && !done; i++) begin
            cycle(1'b1, 5'd3, 64'hA000 + 64'(alu_cnt), 1'b0, 5'd0, 64'd0, 2'd0, 3'd0, at, lt, rdy);
            if (at) alu_cnt++;
            if (rdy) wins++;
            else     done = 1'b1;
        end
        check("starve_alu_wins", wins, STARVE_LIMIT);
        cycle(1'b1, 5'd3, 64'hA000 + 64'(alu_cnt), 1'b0, 5'd0, 64'd0, 2'd0, 3'd0, at, lt, rdy);
        if (at) alu_cnt++;
        check("alu_resumes", rdy, 1);
        drain();

        // Full and pointer wrap: ALU saturates the port while DEPTH+2 loads arrive
        n_ld      = 0;
        full_seen = 1'b0;
        for (int unsigned i = 0; i < 200 && n_ld < DEPTH + 2; i++) begin
            cycle(1'b1, 5'(1 + alu_cnt % 31), 64'hB000 + 64'(alu_cnt),
                  1'b1, 5'(16 + n_ld), 64'hC0DE000000000000 + 64'(n_ld),
                  2'(n_ld % 4), 3'((n_ld * 3) % 8), at, lt, rdy);
            if (at) alu_cnt++;
            if (lt) n_ld++;
            if (FIFO_LEVEL == LW'(DEPTH) && LD_READY == 1'b0) full_seen = 1'b1;
        end
        check("full_ready_low", full_seen, 1);
        drain();

        // Random traffic with held-until-accepted producers
        a_pend = 1'b0;
        l_pend = 1'b0;
        a_addr = '0; a_data = '0; l_addr = '0; l_data = '0; l_size = '0; l_off = '0;
        for (int unsigned i = 0; i < 300; i++) begin
            if (!a_pend) begin
                a_pend = ($urandom_range(0, 2) == 0);
                a_addr = 5'($urandom);
                a_data = {$urandom, $urandom};
            end
            if (!l_pend) begin
                l_pend = ($urandom_range(0, 1) == 1);
                l_addr = 5'($urandom);
                l_data = {$urandom, $urandom};
                l_size = 2'($urandom);
                l_off  = 3'($urandom);
            end
            cycle(a_pend, a_addr, a_data, l_pend, l_addr, l_data, l_size, l_off, at, lt, rdy);
            if (at) a_pend = 1'b0;
            if (lt) l_pend = 1'b0;
        end
        drain();

        // Reset mid-burst with three loads queued behind a busy ALU
        for (int unsigned i = 0; i < 3; i++) begin
            cycle(1'b1, 5'd4, 64'hD000 + 64'(i), 1'b1, 5'(20 + i), 64'hE000 + 64'(i),
                  2'd1, 3'd0, at, lt, rdy);
        end
        check("pre_reset_level", FIFO_LEVEL, 3);
        do_reset();
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wb_driver.md
# regfile_wb_driver

Write-side driver for the 64-bit, 32-entry register file. It merges two producers into the register file's single write port and drives RegWrite, W_ADDR, W_DATA and W_MASK:
- full-width ALU results;
- sub-word load returns, which it buffers and converts to byte-lane masks.

It sits between the execute/memory stages and the register file. It fixes arbitration, buffering and starvation rules so the register file sees at most one write per cycle.

## Interface
Parameters:
- DEPTH, 4, load FIFO entries (power of two, 2..16)
- STARVE_LIMIT, 8, consecutive cycles a queued load may lose arbitration before it is forced through (1..255)

Ports (bit vectors are [0:N-1]; bit 0 is most significant):
- CLK  in  1  clock; all state updates on posedge
- RST_N  in  1  asynchronous, active-low reset
- ALU_VALID  in  1  ALU result present
- ALU_READY  out  1  ALU result accepted this cycle when high
- ALU_ADDR  in  5  destination register
- ALU_DATA  in  64  result
- LD_VALID  in  1  load return present
- LD_READY  out  1  FIFO can accept a load
- LD_ADDR  in  5  destination register
- LD_DATA  in  64  raw aligned doubleword from memory
- LD_SIZE  in  2  0=byte, 1=half, 2=word, 3=dword
- LD_OFFSET  in  3  starting byte lane (lane 0 = bits 0..7)
- RegWrite  out  1  write strobe to register file
- W_ADDR  out  5  write address
- W_DATA  out  64  write data
- W_MASK  out  8  byte-lane enables; W_MASK[i] covers W_DATA[8*i +: 8]
- LD_ERR  out  1  one-cycle pulse: accepted load crossed lane 7
- FIFO_LEVEL  out  $clog2(DEPTH)+1  current load FIFO occupancy

## Operation
- **Load FIFO:**
  - A load is accepted on a cycle with LD_VALID & LD_READY.
  - At acceptance the block computes the mask and stores {addr, data, mask}.
  - Mask covers lanes OFFSET .. OFFSET+2^SIZE-1.
  - If the range extends past lane 7, the mask is truncated at lane 7, the truncated write is still stored, and LD_ERR pulses the cycle after acceptance.
  - W_DATA for a load is LD_DATA unmodified; the register file keeps the unmasked lanes.
- **LD_READY:** registered; high iff FIFO not full after this cycle's push/pop. A pop while full does not make LD_READY high in the same cycle.
- **Arbitration**, evaluated each cycle (priority order):
  - (1) starve counter == STARVE_LIMIT and FIFO non-empty → ALU_READY=0 and FIFO head issues.
  - (2) ALU_VALID → ALU issues with W_MASK=8'hFF.
  - (3) FIFO non-empty → head pops and issues.
  - (4) otherwise idle.
- **ALU_READY:** combinational, equals NOT case (1). ALU_VALID with ALU_READY=0 must be held by the producer.
- **Starve counter** (8 bits):
  - increments when the FIFO is non-empty and the ALU wins;
  - clears whenever a load issues or the FIFO is empty;
  - saturates at STARVE_LIMIT.
- **Address-0 writes** are handled according to the Configuration section.
- **Same-cycle accept:** a load accepted in cycle t is not eligible to issue in cycle t.

## Timing
- All outputs except ALU_READY are registered.
- Reset values:
  - RegWrite=0, W_ADDR=0, W_DATA=0, W_MASK=0;
  - LD_ERR=0, FIFO_LEVEL=0;
  - LD_READY=0, rising at the first posedge after RST_N deasserts;
  - FIFO empty, starve counter 0.
- ALU accepted in cycle t → RegWrite=1 with ALU data in cycle t+1.
- Load accepted in cycle t, FIFO otherwise empty, no ALU in t+1 → RegWrite=1 in cycle t+2.
- RegWrite is high for exactly one cycle per issued write. Back-to-back writes give continuous RegWrite.
- Simultaneous push and pop leaves FIFO_LEVEL unchanged. Pointers wrap modulo DEPTH.
- Reset asserted mid-operation discards queued loads immediately; no partial write is emitted.

## Configuration
- Macro WB_ZERO_FILTER_EN.
- **Defined:** writes with destination 0 (ALU or load) are accepted and consumed normally but issue with RegWrite=0. Arbitration and the starve counter behave as if the write issued.
- **Undefined:** destination-0 writes are driven to the register file with RegWrite=1; the register file ignores them.

## Test plan
- **Reset:** RST_N low mid-burst with 3 loads queued → all outputs 0, FIFO_LEVEL=0; LD_READY=1 one cycle after release.
- **ALU path:** ALU_VALID, ALU_ADDR=5, ALU_DATA=64'h0123456789ABCDEF at t → RegWrite=1, W_ADDR=5, W_MASK=8'hFF at t+1.
- **Load masks:**
  - SIZE=1, OFFSET=2, ADDR=7 → W_MASK=8'b00110000 at t+2.
  - SIZE=2, OFFSET=6 → W_MASK=8'b00000011 and LD_ERR pulse at t+1.
- **Starvation:** ALU_VALID held high continuously, one load queued, STARVE_LIMIT=8 → 8 ALU writes, then ALU_READY=0 for one cycle with the load issued, then ALU resumes.
- **Full/wrap:** push DEPTH+2 loads with ALU saturating the port → LD_READY=0 at FIFO_LEVEL=DEPTH. All loads then issue in order across pointer wrap, with no drop or duplicate.
- **Zero filter:** ALU_ADDR=0 → RegWrite=0 when WB_ZERO_FILTER_EN is defined, RegWrite=1 with W_ADDR=0 when undefined.
